// File: rtl/dcpu16_pkg.sv
// Shared DCPU-16 definitions: basic opcodes, pipeline phases and
// divider iteration counts used by the ALU, memory bus and control stages.
package dcpu16_pkg;

    // Basic instruction opcodes, ireg[3:0]
    typedef enum logic [3:0] {
        OP_NBI = 4'h0,
        OP_SET = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_MUL = 4'h4,
        OP_DIV = 4'h5,
        OP_MOD = 4'h6,
        OP_SHL = 4'h7,
        OP_SHR = 4'h8,
        OP_AND = 4'h9,
        OP_BOR = 4'hA,
        OP_XOR = 4'hB,
        OP_IFE = 4'hC,
        OP_IFN = 4'hD,
        OP_IFG = 4'hE,
        OP_IFB = 4'hF
    } opcode_t;

    // Pipeline phases driven by the control stage
    localparam logic [1:0] PHA_EXEC  = 2'o0;
    localparam logic [1:0] PHA_FETCH = 2'o1;
    localparam logic [1:0] PHA_LOADA = 2'o2;
    localparam logic [1:0] PHA_LOADB = 2'o3;

    // Divider iteration counts: the divide opcode needs the full 32-bit
    // quotient, while the remainder opcode only needs the upper 16 dividend bits
    localparam logic [5:0] DIV_ITER_DIV = 6'd32;
    localparam logic [5:0] DIV_ITER_MOD = 6'd16;

    // Conditional (IFx) opcodes occupy the top quarter of the opcode space
    function automatic logic is_if_op(input opcode_t op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/dcpu16_div.sv
// Restoring shift-subtract divider: 32-bit dividend, 16-bit divisor,
// one quotient bit per cycle. 'done' and the quotient/remainder outputs
// are combinational and describe the state after the final iteration edge,
// so the caller can capture the result on the same edge busy drops.
module dcpu16_div
    import dcpu16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    input  logic [5:0]  iter_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [15:0] remainder
);

    logic [31:0] dvd_reg;
    logic [15:0] dsr_reg;
    logic [15:0] rem_reg;
    logic [31:0] quo_reg;
    logic [5:0]  cnt_reg;
    logic [5:0]  iter_reg;
    logic        busy_reg;

    logic [16:0] trial;
    logic [16:0] diff;
    logic        fits;
    logic [15:0] rem_next;
    logic [31:0] quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial    = {rem_reg, dvd_reg[31]};
        diff     = trial - {1'b0, dsr_reg};
        fits     = (trial >= {1'b0, dsr_reg});
        // Partial remainder always stays below the divisor, so 16 bits suffice
        rem_next = fits ? diff[15:0] : trial[15:0];
        quo_next = {quo_reg[30:0], fits};
    end

    assign done      = busy_reg && (cnt_reg == (iter_reg - 6'd1));
    assign busy      = busy_reg;
    assign quotient  = quo_next;
    assign remainder = rem_next;

    // Iteration state: load on start, step every cycle while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_reg  <= 32'h0;
            dsr_reg  <= 16'h0;
            rem_reg  <= 16'h0;
            quo_reg  <= 32'h0;
            cnt_reg  <= 6'd0;
            iter_reg <= 6'd0;
            busy_reg <= 1'b0;
        end else if (start && !busy_reg) begin
            dvd_reg  <= dividend;
            dsr_reg  <= divisor;
            rem_reg  <= 16'h0;
            quo_reg  <= 32'h0;
            cnt_reg  <= 6'd0;
            iter_reg <= iter_count;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            dvd_reg <= {dvd_reg[30:0], 1'b0};
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (done) begin
                cnt_reg  <= 6'd0;
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 6'd1;
            end
        end
    end

endmodule

// File: rtl/dcpu16_alu.sv
// DCPU-16 execute stage. Single-cycle ops write res/regO on the start edge
// and pulse wre for the following cycle; DIV and MOD run on the iterative
// divider with busy held high until the result lands.
module dcpu16_alu
    import dcpu16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [1:0]  pha,
    input  logic [15:0] ireg,
    input  logic [15:0] regA,
    input  logic [15:0] regB,
    output logic [15:0] res,
    output logic        wre,
    output logic [15:0] regO,
    output logic        skp,
    output logic        busy
);

    logic [15:0] res_reg, res_next;
    logic [15:0] rego_reg, rego_next;
    logic        wre_reg, wre_next;
    logic        skp_reg, skp_next;
    opcode_t     op_reg, op_next;

    opcode_t     op;
    logic        start;
    logic        div_start;
    logic [5:0]  div_iter;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [15:0] div_remainder;

    logic [16:0] add_full;
    logic [31:0] mul_full;
    logic [31:0] shl_full;
    logic [31:0] shr_full;
    logic [15:0] and_w, bor_w, xor_w;

    // Only the basic opcode field matters here; operand fields are decoded upstream
    logic unused_ireg;
    assign unused_ireg = ^ireg[15:4];

    assign op    = opcode_t'(ireg[3:0]);
    assign start = ena && (pha == PHA_EXEC) && !div_busy;

    // Datapath: adder, multiplier and barrel shifters are inferred inline
    assign add_full = {1'b0, regA} + {1'b0, regB};
    assign mul_full = 32'(regA) * 32'(regB);
    assign shl_full = (regB < 16'd32) ? ({16'h0, regA} << regB[4:0]) : 32'h0;
    assign shr_full = (regB < 16'd32) ? ({regA, 16'h0} >> regB[4:0]) : 32'h0;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bitwise
            assign and_w[gi] = regA[gi] & regB[gi];
            assign bor_w[gi] = regA[gi] | regB[gi];
            assign xor_w[gi] = regA[gi] ^ regB[gi];
        end
    endgenerate

    dcpu16_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .dividend   ({regA, 16'h0}),
        .divisor    (regB),
        .iter_count (div_iter),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quotient),
        .remainder  (div_remainder)
    );

    // Next-state selection: divider completion, or a fresh instruction start
    always_comb begin
        res_next  = res_reg;
        rego_next = rego_reg;
        wre_next  = 1'b0;
        skp_next  = skp_reg;
        op_next   = op_reg;
        div_start = 1'b0;
        div_iter  = DIV_ITER_DIV;

        if (div_done) begin
            wre_next = 1'b1;
            if (op_reg == OP_DIV) begin
                res_next  = div_quotient[31:16];
                rego_next = div_quotient[15:0];
            end else begin
                res_next = div_remainder;
            end
        end else if (start) begin
            op_next  = op;
            // IFx ops overwrite this below; everything else clears a pending skip
            skp_next = 1'b0;
            case (op)
                OP_SET: begin
                    res_next = regB;
                    wre_next = 1'b1;
                end
                OP_ADD: begin
                    res_next  = add_full[15:0];
                    rego_next = add_full[16] ? 16'h0001 : 16'h0000;
                    wre_next  = 1'b1;
                end
                OP_SUB: begin
                    res_next  = regA - regB;
                    rego_next = (regA < regB) ? 16'hFFFF : 16'h0000;
                    wre_next  = 1'b1;
                end
                OP_MUL: begin
                    res_next  = mul_full[15:0];
                    rego_next = mul_full[31:16];
                    wre_next  = 1'b1;
                end
                OP_DIV: begin
                    if (regB == 16'h0) begin
                        res_next  = 16'h0;
                        rego_next = 16'h0;
                        wre_next  = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        div_iter  = DIV_ITER_DIV;
                    end
                end
                OP_MOD: begin
                    if (regB == 16'h0) begin
                        res_next = 16'h0;
                        wre_next = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        div_iter  = DIV_ITER_MOD;
                    end
                end
                OP_SHL: begin
                    res_next  = shl_full[15:0];
                    rego_next = shl_full[31:16];
                    wre_next  = 1'b1;
                end
                OP_SHR: begin
                    res_next  = shr_full[31:16];
                    rego_next = shr_full[15:0];
                    wre_next  = 1'b1;
                end
                OP_AND: begin
                    res_next = and_w;
                    wre_next = 1'b1;
                end
                OP_BOR: begin
                    res_next = bor_w;
                    wre_next = 1'b1;
                end
                OP_XOR: begin
                    res_next = xor_w;
                    wre_next = 1'b1;
                end
                OP_IFE: skp_next = !(regA == regB);
                OP_IFN: skp_next = (regA == regB);
                OP_IFG: skp_next = !(regA > regB);
                OP_IFB: skp_next = (and_w == 16'h0);
                default: ;
            endcase
        end
    end

    // Architectural output registers; reset aborts any divide in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg  <= 16'h0;
            rego_reg <= 16'h0;
            wre_reg  <= 1'b0;
            skp_reg  <= 1'b0;
            op_reg   <= OP_NBI;
        end else begin
            res_reg  <= res_next;
            rego_reg <= rego_next;
            wre_reg  <= wre_next;
            skp_reg  <= skp_next;
            op_reg   <= op_next;
        end
    end

    assign res  = res_reg;
    assign regO = rego_reg;
    assign wre  = wre_reg;
    assign skp  = skp_reg;
    assign busy = div_busy;

    // Sanity check: the classifier helper agrees with the opcode map
    logic unused_if_check;
    assign unused_if_check = is_if_op(op);

endmodule

// File: tb/tb_dcpu16_alu.sv
// Testbench for dcpu16_alu: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_dcpu16_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [1:0]  pha = 2'o1;
    logic [15:0] ireg = 16'h0;
    logic [15:0] regA = 16'h0;
    logic [15:0] regB = 16'h0;
    logic [15:0] res;
    logic        wre;
    logic [15:0] regO;
    logic        skp;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [15:0] e_res, e_rego, p_res, p_rego;
    logic        e_wre, e_skp, e_busy, p_has_o;
    int          cd = 0;
    logic        m_valid = 1'b0;

    dcpu16_alu dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .pha  (pha),
        .ireg (ireg),
        .regA (regA),
        .regB (regB),
        .res  (res),
        .wre  (wre),
        .regO (regO),
        .skp  (skp),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model advanced once per rising edge with the sampled inputs
    task automatic model_step(input logic r, input logic en, input logic [1:0] ph,
                              input logic [3:0] op, input logic [15:0] a16, input logic [15:0] b16);
        longint unsigned a, b, t;
        a = 64'(a16);
        b = 64'(b16);
        e_wre = 1'b0;
        if (r) begin
            e_res = 16'h0; e_rego = 16'h0; e_skp = 1'b0; e_busy = 1'b0;
            cd = 0; m_valid = 1'b1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                e_busy = 1'b0;
                e_wre  = 1'b1;
                e_res  = p_res;
                if (p_has_o) e_rego = p_rego;
            end
        end else if (en && ph == 2'o0) begin
            e_skp = 1'b0;
            case (op)
                4'h1: begin e_res = b16; e_wre = 1'b1; end
                4'h2: begin
                    t = a + b;
                    e_res = t[15:0]; e_rego = (t > 64'd65535) ? 16'h0001 : 16'h0000; e_wre = 1'b1;
                end
                4'h3: begin
                    t = a - b;
                    e_res = t[15:0]; e_rego = (a < b) ? 16'hFFFF : 16'h0000; e_wre = 1'b1;
                end
                4'h4: begin
                    t = a * b;
                    e_res = t[15:0]; e_rego = t[31:16]; e_wre = 1'b1;
                end
                4'h5: begin
                    if (b == 0) begin
                        e_res = 16'h0; e_rego = 16'h0; e_wre = 1'b1;
                    end else begin
                        t = (a * 64'd65536) / b;
                        p_res = t[31:16]; p_rego = t[15:0]; p_has_o = 1'b1;
                        cd = 32; e_busy = 1'b1;
                    end
                end
                4'h6: begin
                    if (b == 0) begin
                        e_res = 16'h0; e_wre = 1'b1;
                    end else begin
                        t = a % b;
                        p_res = t[15:0]; p_has_o = 1'b0;
                        cd = 16; e_busy = 1'b1;
                    end
                end
                4'h7: begin
                    t = (b >= 32) ? 64'd0 : (a << b);
                    e_res = t[15:0]; e_rego = t[31:16]; e_wre = 1'b1;
                end
                4'h8: begin
                    t = (b >= 32) ? 64'd0 : ((a * 64'd65536) >> b);
                    e_res = t[31:16]; e_rego = t[15:0]; e_wre = 1'b1;
                end
                4'h9: begin e_res = a16 & b16; e_wre = 1'b1; end
                4'hA: begin e_res = a16 | b16; e_wre = 1'b1; end
                4'hB: begin e_res = a16 ^ b16; e_wre = 1'b1; end
                4'hC: e_skp = !(a == b);
                4'hD: e_skp = (a == b);
                4'hE: e_skp = !(a > b);
                4'hF: e_skp = ((a & b) == 0);
                default: ;
            endcase
        end
    endtask

    // Compare process: step model at each edge, check DUT 1 time unit later
    initial begin : compare_proc
        forever begin
            @(posedge clk);
            model_step(rst, ena, pha, ireg[3:0], regA, regB);
            #1;
            if (m_valid) begin
                chk("res",  32'(res),  32'(e_res));
                chk("regO", 32'(regO), 32'(e_rego));
                chk("wre",  32'(wre),  32'(e_wre));
                chk("skp",  32'(skp),  32'(e_skp));
                chk("busy", 32'(busy), 32'(e_busy));
            end
        end
    end

    // Present one instruction for a single start edge, return at the next negedge
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        ireg = {12'h0, op}; regA = a; regB = b; ena = 1'b1; pha = 2'o0;
        @(negedge clk);
        ena = 1'b0; pha = 2'o1;
    endtask

    // Wait for wre after an iterative start, counting busy cycles
    task automatic wait_result(output int cyc, output int busy_cnt, input int mid_cyc);
        cyc = 1; busy_cnt = 0;
        while (!wre && cyc < 45) begin
            if (busy) busy_cnt++;
            if (cyc == mid_cyc) begin
                ireg = 16'h0001; regB = 16'h1234; ena = 1'b1; pha = 2'o0;
            end else begin
                ena = 1'b0; pha = 2'o1;
            end
            @(negedge clk);
            cyc++;
        end
        ena = 1'b0; pha = 2'o1;
    endtask

    initial begin : stim_proc
        int cyc, bcnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_res",  32'(res),  32'h0);
        chk("reset_regO", 32'(regO), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wre",  32'(wre),  32'h0);

        issue(4'h2, 16'hFFFF, 16'h0002);
        chk("add_res", 32'(res), 32'h0001);
        chk("add_regO", 32'(regO), 32'h0001);
        chk("add_wre", 32'(wre), 32'h1);
        @(negedge clk);
        chk("add_wre_drop", 32'(wre), 32'h0);

        issue(4'h3, 16'h0001, 16'h0002);
        chk("sub_res", 32'(res), 32'hFFFF);
        chk("sub_regO", 32'(regO), 32'hFFFF);
        issue(4'h4, 16'h1234, 16'h0100);
        chk("mul_res", 32'(res), 32'h3400);
        chk("mul_regO", 32'(regO), 32'h0012);

        issue(4'h5, 16'h0007, 16'h0002);
        wait_result(cyc, bcnt, -1);
        chk("div_busy_cycles", 32'(bcnt), 32'd32);
        chk("div_wre_cycle", 32'(cyc), 32'd33);
        chk("div_res", 32'(res), 32'h0003);
        chk("div_regO", 32'(regO), 32'h8000);
        @(negedge clk);

        issue(4'h5, 16'h1111, 16'h0000);
        chk("div0_res", 32'(res), 32'h0);
        chk("div0_regO", 32'(regO), 32'h0);
        chk("div0_busy", 32'(busy), 32'h0);
        chk("div0_wre", 32'(wre), 32'h1);

        issue(4'h2, 16'hFFFF, 16'h0002);   // regO = 1
        issue(4'h6, 16'h0011, 16'h0005);
        wait_result(cyc, bcnt, 5);
        chk("mod_wre_cycle", 32'(cyc), 32'd17);
        chk("mod_busy_cycles", 32'(bcnt), 32'd16);
        chk("mod_res", 32'(res), 32'h0002);
        chk("mod_regO", 32'(regO), 32'h0001);
        @(negedge clk);

        issue(4'hC, 16'h0005, 16'h0006);
        chk("ife_skp", 32'(skp), 32'h1);
        chk("ife_wre", 32'(wre), 32'h0);
        issue(4'h1, 16'h0000, 16'h00AA);
        chk("set_skp", 32'(skp), 32'h0);
        chk("set_res", 32'(res), 32'h00AA);
        issue(4'h7, 16'h8001, 16'h0001);
        chk("shl_res", 32'(res), 32'h0002);
        chk("shl_regO", 32'(regO), 32'h0001);

        issue(4'h5, 16'h1234, 16'h0007);
        cyc = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_wre", 32'(wre), 32'h0);
        chk("abort_regO", 32'(regO), 32'h0);
        repeat (30) begin
            @(negedge clk);
            chk("abort_no_wre", 32'(wre), 32'h0);
        end
        issue(4'h5, 16'hFFFF, 16'h0003);
        wait_result(cyc, bcnt, -1);
        chk("div2_res", 32'(res), 32'h5555);
        chk("div2_regO", 32'(regO), 32'h0000);
        chk("div2_wre_cycle", 32'(cyc), 32'd33);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) == 0);
            ena  = ($urandom_range(0, 9) < 7);
            pha  = ($urandom_range(0, 1) == 0) ? 2'o0 : 2'($urandom_range(1, 3));
            ireg = 16'($urandom);
            regA = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            case ($urandom_range(0, 7))
                0:       regB = 16'h0;
                1, 2:    regB = 16'($urandom_range(0, 40));
                3:       regB = regA;
                default: regB = 16'($urandom);
            endcase
        end
        @(negedge clk);
        rst = 1'b0; ena = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcpu16_alu.md
DCPU16_ALU -- requirements
Module: dcpu16_alu

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-003 ena  input  1  pipe-advance from memory bus stage; operands sampled only when high.
REQ-004 pha  input  2  current pipeline phase; execute start when pha==2'o0 and ena==1.
REQ-005 ireg  input  16  instruction word; opcode = ireg[3:0].
REQ-006 regA  input  16  operand A (target value) from memory bus stage.
REQ-007 regB  input  16  operand B (source value) from memory bus stage.
REQ-008 res  output  16  result value for write-back.
REQ-009 wre  output  1  one-cycle pulse; res valid for write-back to A.
REQ-010 regO  output  16  overflow register O.
REQ-011 skp  output  1  level; next instruction to be skipped; cleared on next start.
REQ-012 busy  output  1  multi-cycle op in progress; upstream ANDs ~busy into ena.

Function
REQ-013 Start = ena & (pha==2'o0) & ~busy; operands and opcode latched at start edge; start while busy ignored.
REQ-014 Single-cycle ops (SET,ADD,SUB,MUL,SHL,SHR,AND,BOR,XOR): res/regO/wre update at the start edge itself; wre high for exactly the following cycle.
REQ-015 SET(1): res=B; regO unchanged.
REQ-016 ADD(2): res=(A+B)[15:0]; regO=16'h0001 on carry else 16'h0000.
REQ-017 SUB(3): res=(A-B)[15:0]; regO=16'hFFFF on borrow else 16'h0000.
REQ-018 MUL(4): 32-bit product; res=bits[15:0], regO=bits[31:16]; single cycle.
REQ-019 DIV(5): B==0 -> res=0, regO=0, single cycle; else quotient of {A,16'h0}/B over 32 iterations, res=q[31:16], regO=q[15:0].
REQ-020 MOD(6): B==0 -> res=0, single cycle; else A%B over 16 iterations; regO unchanged.
REQ-021 SHL(7): 32-bit {16'h0,A}<<B; res=[15:0], regO=[31:16]; B>=32 gives 0/0.
REQ-022 SHR(8): 32-bit {A,16'h0}>>B; res=[31:16], regO=[15:0]; B>=32 gives 0/0.
REQ-023 AND(9), BOR(A), XOR(B): bitwise; regO unchanged.
REQ-024 IFE(C),IFN(D),IFG(E, unsigned A>B),IFB(F, (A&B)!=0): wre=0, res unchanged; skp=1 when condition false, else 0.
REQ-025 Opcode 0 (non-basic): no-op; wre=0, skp=0, regO unchanged.
REQ-026 Non-IF ops clear skp at start.
REQ-027 Iterative ops: busy=1 from cycle after start through last iteration; busy falls and wre pulses in the same cycle res/regO become valid; latency DIV 33 cycles, MOD 17 cycles start-to-wre.
REQ-028 Operands held internally; regA/regB/ireg changes during busy have no effect.
REQ-029 ena ignored for iteration progress: divider runs while busy irrespective of ena.

Reset
REQ-030 rst: res=0, regO=0, wre=0, skp=0, busy=0, divider iteration counter=0.
REQ-031 rst during busy aborts the operation; no wre pulse, regO not updated.
REQ-032 rst overrides simultaneous start.

Structure
REQ-033 Opcode constants (OP_SET..OP_IFB) and phase constants shared in package dcpu16_pkg, also used by the memory bus and control stages.
REQ-034 One sub-module dcpu16_div: restoring shift-subtract divider, 32-bit dividend, 16-bit divisor, start/done handshake, iteration-count input (16 or 32).
REQ-035 Multiplier and shifter inferred inline, no sub-module.

Verification
REQ-036 ADD A=16'hFFFF,B=16'h0002 -> res=16'h0001, regO=16'h0001, wre one cycle after start.
REQ-037 SUB A=16'h0001,B=16'h0002 -> res=16'hFFFF, regO=16'hFFFF; MUL A=16'h1234,B=16'h0100 -> res=16'h3400, regO=16'h0012.
REQ-038 DIV A=16'h0007,B=16'h0002 -> busy 32 cycles, res=16'h0003, regO=16'h8000, wre at cycle 33; DIV B=0 -> res=0, regO=0, no busy.
REQ-039 MOD A=16'h0011,B=16'h0005 -> res=16'h0002 at cycle 17, regO unchanged; second start during busy ignored.
REQ-040 IFE A=5,B=6 -> skp=1, wre=0; following SET B=16'h00AA -> skp=0, res=16'h00AA; SHL A=16'h8001,B=1 -> res=16'h0002, regO=16'h0001.
REQ-041 rst asserted at DIV iteration 10 -> busy=0 next cycle, no wre, regO=0; fresh DIV afterwards completes correctly.
